// File: rtl/andrewm_uart_to_parallel.sv
// andrewm_uart_to_parallel
// UART receiver, 8N1, LSB first. Recovers bytes from the serial line, holds each
// in a one-byte buffer with a valid/ack handshake, and presents it both as a byte
// and as a selectable nibble. Bit timing matches the parallel-to-UART transmitter.
//
// Parameters:
//   CLKS_PER_BIT  clocks per bit period (4..256, even)
// Ports:
//   clk         single clock, all state on posedge
//   reset_n     asynchronous active-low reset (deassert synchronously at system level)
//   rx          serial line, idle high, asynchronous to clk
//   rx_ack      consumer accepts the held byte
//   err_clr     clears the sticky overrun / frame_err flags
//   nibble_sel  0: low nibble of rx_data, 1: high nibble
//   rx_data     held byte
//   rx_valid    rx_data holds an unacknowledged byte
//   nibble_out  nibble mux of rx_data
//   busy        receiver FSM not idle
//   frame_err   sticky: stop bit sampled low
//   overrun     sticky: byte completed while buffer full and not acked
// Configuration:
//   ANDREWM_RX_MAJORITY_EN  when defined, each bit decision is the 2-of-3 majority of
//                           the synchronized line at expiry-1, expiry and expiry+1.

module andrewm_uart_to_parallel #(
    parameter int unsigned CLKS_PER_BIT = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       rx_ack,
    input  logic       err_clr,
    input  logic       nibble_sel,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [3:0] nibble_out,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [7:0] HalfLoad = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] FullLoad = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e     state_q;
    logic       rx_meta_q, rx_s_q, rx_prev_q;
    logic [7:0] bit_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shreg_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, frame_err_q, overrun_q;

    logic expiry, counting, fall;
    logic samp_go, samp;

    assign expiry   = (bit_cnt_q == 8'd0);
    assign counting = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    assign fall     = rx_prev_q & ~rx_s_q;

`ifdef ANDREWM_RX_MAJORITY_EN
    // Decision is made one cycle after expiry, once the expiry+1 sample is available.
    // The counter has already been reloaded by then, so frame timing is unchanged.
    logic s_early_q, s_mid_q, samp_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_early_q   <= 1'b1;
            s_mid_q     <= 1'b1;
            samp_pend_q <= 1'b0;
        end else begin
            if (bit_cnt_q == 8'd1) s_early_q <= rx_s_q;
            if (counting && expiry) s_mid_q <= rx_s_q;
            samp_pend_q <= counting && expiry;
        end
    end

    assign samp_go = samp_pend_q;
    assign samp    = (s_early_q & s_mid_q) | (s_early_q & rx_s_q) | (s_mid_q & rx_s_q);
`else
    assign samp_go = counting && expiry;
    assign samp    = rx_s_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            bit_cnt_q   <= 8'd0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;

            // Bit-period counter; reloads at every expiry while a frame is in flight.
            unique case (state_q)
                StIdle:                  bit_cnt_q <= fall ? HalfLoad : 8'd0;
                StStart, StData, StStop: bit_cnt_q <= expiry ? FullLoad : bit_cnt_q - 8'd1;
                default:                 bit_cnt_q <= 8'd0;
            endcase

            if (rx_ack && rx_valid_q) rx_valid_q <= 1'b0;
            // Clears come first so that a set later in this block wins.
            if (err_clr) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (fall) state_q <= StStart;
                end
                StStart: begin
                    if (samp_go) begin
                        bit_idx_q <= 3'd0;
                        state_q   <= samp ? StIdle : StData;
                    end
                end
                StData: begin
                    if (samp_go) begin
                        shreg_q[bit_idx_q] <= samp;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= StStop;
                    end
                end
                StStop: begin
                    if (samp_go) begin
                        if (samp) begin
                            // An ack in the delivery cycle frees the buffer for the new byte.
                            if (!rx_valid_q || rx_ack) begin
                                rx_data_q  <= shreg_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    // Hold here until the line returns high so a stuck-low line
                    // is not taken as a stream of start bits.
                    if (rx_s_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign nibble_out = nibble_sel ? rx_data_q[7:4] : rx_data_q[3:0];
    assign busy       = (state_q != StIdle);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
